regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised successor to the CPU's integer register file.
- Configurable data width, register count and number of read ports.
- Hardwired-zero register 0, and a per-register busy scoreboard for the hazard unit.
- Sits between decode (read addresses, destination issue) and writeback (write port).
- Reads are combinational; writes and scoreboard updates are synchronous.

Parameters:
XLEN, 32, data width of each register and of WD/RD.
NREG, 32, number of architectural registers; power of two, at least 2.
NRD, 2, number of independent read ports, 1 to 4.
AW, $clog2(NREG), derived localparam; address width, not overridable.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  reset; synchronous, active-high. Clears every register and every busy bit on the next CLK edge.
WE  input  1  write enable.
WA  input  AW  write address.
WD  input  XLEN  write data.
RA  input  NRD*AW  read addresses; port i uses RA[i*AW +: AW].
RD  output  NRD*XLEN  read data; port i uses RD[i*XLEN +: XLEN].
ISS  input  1  issue strobe; marks destination ISS_A busy.
ISS_A  input  AW  destination register being issued.
BUSY  output  NRD  BUSY[i] = scoreboard bit of RA port i.
ANY_BUSY  output  1  OR of all busy bits; drain indicator for fence/flush.

Behaviour:
- Storage: NREG x XLEN flops. Register 0 is never written, always reads 0 and is never busy.
- Write: when WE=1 and WA!=0, mem[WA] <= WD on the rising edge. Visible on RD the cycle after the edge.
- Read: RD port i = mem[RA_i], purely combinational, zero latency. All NRD ports are fully independent; any ports may alias the same address.
- Scoreboard state: busy[NREG-1:0], with busy[0] tied to 0.
  - ISS=1 and ISS_A!=0: busy[ISS_A] <= 1.
  - WE=1 and WA!=0: busy[WA] <= 0.
  - Same address on both in the same cycle: set wins, so the busy bit ends at 1 (the new producer is outstanding).
  - Different addresses in the same cycle: both updates apply.
- BUSY[i] = busy[RA_i], combinational. ANY_BUSY = |busy.
- ISS to an already-busy register: the bit stays 1. No error is flagged; WAW ordering is the issue logic's responsibility.
- WE to a non-busy register: the write is performed and the busy bit stays 0.
- Reset: RST=1 at an edge forces every mem entry and busy bit to 0. RST dominates WE and ISS in the same cycle.
  - Outputs after reset: RD = 0 on all ports, BUSY = 0, ANY_BUSY = 0.
  - Mid-operation reset discards all outstanding busy bits.
- Outputs have no X: flops carry an initial value of 0 for simulation, matching the existing Register convention.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If WE=1, WA!=0 and RA_i==WA in the same cycle, RD port i = WD and BUSY[i] = 0 in that cycle, unless ISS=1 with ISS_A==WA. Zero-cycle writeback-to-decode path.
- Undefined: RD returns the pre-edge stored value and BUSY reflects the stored bit. The consumer stalls one extra cycle.

Decomposition:
- Package regfile_pkg: XLEN default, REG_ZERO = 0, helper function for the port-slice index.
- One natural sub-module, regfile_rd_port, instanced NRD times via generate. Contents: read mux, zero-force, BUSY lookup and the optional bypass compare.
- Storage and scoreboard stay in the top module.

Test Plan:
1. Reset, then read all ports at addresses 0..NREG-1 -> RD=0, BUSY=0, ANY_BUSY=0.
2. WE=1, WA=5, WD=0xDEADBEEF; next cycle RA0=5, RA1=0 -> RD0=0xDEADBEEF, RD1=0. Then WE=1, WA=0, WD=0xFFFFFFFF; next cycle RA1=0 -> RD1=0.
3. ISS=1, ISS_A=7; next cycle RA0=7 -> BUSY[0]=1, ANY_BUSY=1. WE=1, WA=7, WD=0x12; next cycle -> BUSY[0]=0, RD0=0x12, ANY_BUSY=0.
4. Same cycle: ISS=1, ISS_A=9 and WE=1, WA=9, WD=0x55 -> next cycle RD=0x55 at address 9, BUSY=1 at address 9. Same cycle: ISS_A=3 and WA=4 -> busy[3]=1 and busy[4]=0.
5. With REGFILE_BYPASS_EN: mem[10]=0x1, then WE=1, WA=10, WD=0xAB, RA0=10 in the same cycle -> RD0=0xAB in that cycle. Without the macro -> RD0=0x1 in that cycle, 0xAB on the next.
6. Busy set on registers 2, 3 and 31, with mem[2]=0x77; assert RST together with WE=1, WA=2, WD=0x99 -> next cycle all RD=0, BUSY=0, ANY_BUSY=0, and register 2 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised integer register file.
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ZERO     = 0;

  // Low bit of lane idx in a bus of equal-width lanes.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: read mux, register-0 force and busy lookup.
// Write-first forwarding from the write port is included when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]   i_ra,
  input  logic [XLEN-1:0] i_mem [NREG],
  input  logic [NREG-1:0] i_busy,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic            i_iss,
  input  logic [AW-1:0]   i_iss_a,
  output logic [XLEN-1:0] o_rd,
  output logic            o_busy
);

  logic            w_is_zero;
  logic [XLEN-1:0] w_stored;
  logic            w_stored_busy;

  assign w_is_zero     = (i_ra == AW'(REG_ZERO));
  assign w_stored      = w_is_zero ? '0 : i_mem[i_ra];
  assign w_stored_busy = w_is_zero ? 1'b0 : i_busy[i_ra];

`ifdef REGFILE_BYPASS_EN
  logic w_hit;
  logic w_reissue;

  assign w_hit     = i_we && (i_wa != AW'(REG_ZERO)) && (i_ra == i_wa);
  // A same-cycle issue to the written register keeps the consumer stalled on the new producer.
  assign w_reissue = i_iss && (i_iss_a == i_wa);
  assign o_rd      = w_hit ? i_wd : w_stored;
  assign o_busy    = (w_hit && !w_reissue) ? 1'b0 : w_stored_busy;
`else
  logic w_unused_bypass;

  assign w_unused_bypass = ^{i_we, i_wa, i_wd, i_iss, i_iss_a};
  assign o_rd            = w_stored;
  assign o_busy          = w_stored_busy;
`endif

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with hardwired-zero r0 and a per-register busy scoreboard.
// Optional write-first forwarding on the read ports via REGFILE_BYPASS_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEFAULT,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WE,
  input  logic [AW-1:0]       WA,
  input  logic [XLEN-1:0]     WD,
  input  logic [NRD*AW-1:0]   RA,
  output logic [NRD*XLEN-1:0] RD,
  input  logic                ISS,
  input  logic [AW-1:0]       ISS_A,
  output logic [NRD-1:0]      BUSY,
  output logic                ANY_BUSY
);

  logic [XLEN-1:0] r_mem [NREG] = '{default: '0};
  logic [NREG-1:1] r_busy       = '0;
  logic [NREG-1:0] w_busy;
  logic            w_wr;

  assign w_wr     = WE && (WA != AW'(REG_ZERO));
  assign w_busy   = {r_busy, 1'b0};
  assign ANY_BUSY = |r_busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NREG; k++) r_mem[k] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr) r_mem[WA] <= WD;
      // Issue is checked first so a same-address issue and writeback leaves the bit set.
      for (int k = 1; k < NREG; k++) begin
        if (ISS && (ISS_A == AW'(k)))   r_busy[k] <= 1'b1;
        else if (WE && (WA == AW'(k)))  r_busy[k] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    regfile_rd_port #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
    ) u_rd_port (
      .i_ra    (RA[slice_lo(g, AW) +: AW]),
      .i_mem   (r_mem),
      .i_busy  (w_busy),
      .i_we    (WE),
      .i_wa    (WA),
      .i_wd    (WD),
      .i_iss   (ISS),
      .i_iss_a (ISS_A),
      .o_rd    (RD[slice_lo(g, XLEN) +: XLEN]),
      .o_busy  (BUSY[g])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (default 32 x 32-bit, two read ports).
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                CLK = 1'b0;
  logic                RST;
  logic                WE;
  logic [AW-1:0]       WA;
  logic [XLEN-1:0]     WD;
  logic [NRD*AW-1:0]   RA;
  logic [NRD*XLEN-1:0] RD;
  logic                ISS;
  logic [AW-1:0]       ISS_A;
  logic [NRD-1:0]      BUSY;
  logic                ANY_BUSY;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WE       (WE),
    .WA       (WA),
    .WD       (WD),
    .RA       (RA),
    .RD       (RD),
    .ISS      (ISS),
    .ISS_A    (ISS_A),
    .BUSY     (BUSY),
    .ANY_BUSY (ANY_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ra(input int a0, input int a1);
    RA = {AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    WE = 1'b0; ISS = 1'b0; RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; WE = 1'b0; WA = '0; WD = '0; ISS = 1'b0; ISS_A = '0; RA = '0;
    tick();
    RST = 1'b0;

    // 1: everything reads zero and idle after reset
    for (int a = 0; a < NREG; a++) begin
      set_ra(a, NREG - 1 - a);
      #1;
      chk("rst_rd0", RD[31:0], 32'h0);
      chk("rst_rd1", RD[63:32], 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_any", 32'(ANY_BUSY), 32'h0);
    end

    // 2: plain write, and writes to r0 are dropped
    WE = 1'b1; WA = 5'd5; WD = 32'hDEADBEEF;
    tick();
    idle(); set_ra(5, 0); #1;
    chk("wr5_rd0", RD[31:0], 32'hDEADBEEF);
    chk("wr5_rd1_r0", RD[63:32], 32'h0);
    WE = 1'b1; WA = 5'd0; WD = 32'hFFFFFFFF;
    tick();
    idle(); set_ra(5, 0); #1;
    chk("wr0_rd1", RD[63:32], 32'h0);
    chk("wr0_any", 32'(ANY_BUSY), 32'h0);

    // 3: issue sets busy, writeback clears it
    ISS = 1'b1; ISS_A = 5'd7;
    tick();
    idle(); set_ra(7, 5); #1;
    chk("iss7_busy", 32'(BUSY), 32'h1);
    chk("iss7_any", 32'(ANY_BUSY), 32'h1);
    WE = 1'b1; WA = 5'd7; WD = 32'h12;
    tick();
    idle(); #1;
    chk("wb7_busy", 32'(BUSY), 32'h0);
    chk("wb7_rd0", RD[31:0], 32'h12);
    chk("wb7_any", 32'(ANY_BUSY), 32'h0);

    // 4: same-address issue+write: set wins; different addresses: both apply
    ISS = 1'b1; ISS_A = 5'd9; WE = 1'b1; WA = 5'd9; WD = 32'h55;
    tick();
    idle(); set_ra(9, 0); #1;
    chk("same_rd", RD[31:0], 32'h55);
    chk("same_busy", 32'(BUSY), 32'h1);
    chk("same_any", 32'(ANY_BUSY), 32'h1);
    ISS = 1'b1; ISS_A = 5'd4;
    tick();
    ISS = 1'b1; ISS_A = 5'd3; WE = 1'b1; WA = 5'd4; WD = 32'h44;
    tick();
    idle(); set_ra(3, 4); #1;
    chk("diff_busy", 32'(BUSY), 32'h1);
    chk("diff_rd1", RD[63:32], 32'h44);
    WE = 1'b1; WA = 5'd9; WD = 32'h56;
    tick();
    WE = 1'b1; WA = 5'd3; WD = 32'h33;
    tick();
    idle(); set_ra(9, 3); #1;
    chk("drain_busy", 32'(BUSY), 32'h0);
    chk("drain_any", 32'(ANY_BUSY), 32'h0);
    chk("drain_rd0", RD[31:0], 32'h56);

    // 5: same-cycle write and read of register 10
    WE = 1'b1; WA = 5'd10; WD = 32'h1;
    tick();
    WE = 1'b1; WA = 5'd10; WD = 32'hAB; set_ra(10, 0); #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd0", RD[31:0], 32'hAB);
`else
    chk("byp_rd0", RD[31:0], 32'h1);
`endif
    chk("byp_busy", 32'(BUSY), 32'h0);
    tick();
    idle(); #1;
    chk("byp_rd0_next", RD[31:0], 32'hAB);

    // 6: reset mid-operation discards busy bits and dominates write and issue
    WE = 1'b1; WA = 5'd2; WD = 32'h77;
    tick();
    WE = 1'b0; ISS = 1'b1; ISS_A = 5'd2;
    tick();
    ISS_A = 5'd3;
    tick();
    ISS_A = 5'd31;
    tick();
    idle(); set_ra(2, 31); #1;
    chk("pre_busy", 32'(BUSY), 32'h3);
    chk("pre_rd0", RD[31:0], 32'h77);
    RST = 1'b1; WE = 1'b1; WA = 5'd2; WD = 32'h99; ISS = 1'b1; ISS_A = 5'd5;
    tick();
    idle(); #1;
    chk("post_rd0", RD[31:0], 32'h0);
    chk("post_rd1", RD[63:32], 32'h0);
    chk("post_busy", 32'(BUSY), 32'h0);
    chk("post_any", 32'(ANY_BUSY), 32'h0);
    set_ra(5, 10); #1;
    chk("post_rd5", RD[31:0], 32'h0);
    chk("post_rd10", RD[63:32], 32'h0);
    chk("post_busy5", 32'(BUSY), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
